// File: rtl/bcd_ascii_serializer.sv
// Serializes a packed BCD word into ASCII digits, most significant digit first,
// with optional leading-zero suppression and a saturating invalid-digit counter.
module bcd_ascii_serializer #(
  parameter int          DIGITS   = 4,
  parameter bit          LZ_EN    = 1'b0,
  parameter logic [7:0]  ERR_CHAR = 8'h3F
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_char,
  output logic                  out_last,
  output logic                  out_err,
  output logic [7:0]            err_cnt
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                   state, state_nxt;
  logic [DIGITS-1:0][3:0]   word_q;
  logic [IW-1:0]            idx_q, idx_nxt, idx_start;
  logic [DIGITS-1:0]        nz;
  logic [3:0]               cur_dig;
  logic                     load;

  // Any non-zero nibble (including invalid ones) counts for leading-zero detection.
  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_nz
      assign nz[g] = |in_bcd[4*g +: 4];
    end
  endgenerate

  always_comb begin
    idx_start = IW'(DIGITS - 1);
    if (LZ_EN) begin
      idx_start = '0;
      for (int i = 0; i < DIGITS; i++)
        if (nz[i]) idx_start = IW'(i);
    end
  end

  assign cur_dig = word_q[idx_q];

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx_q;
    load      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_char  = 8'h00;
    out_last  = 1'b0;
    out_err   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) begin
          state_nxt = SEND;
          idx_nxt   = idx_start;
          load      = 1'b1;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        out_last  = (idx_q == '0);
        out_err   = (cur_dig > 4'd9);
        out_char  = out_err ? ERR_CHAR : {4'h3, cur_dig};
        if (out_ready) begin
          if (out_last) state_nxt = IDLE;
          else          idx_nxt   = idx_q - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      state <= state_nxt;
      idx_q <= idx_nxt;
      if (load) word_q <= in_bcd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_cnt <= 8'h00;
    else if (out_valid && out_ready && out_err && (err_cnt != 8'hFF))
      err_cnt <= err_cnt + 8'd1;
  end
endmodule

// File: tb/tb_bcd_ascii_serializer.sv
// Randomized and directed checks of bcd_ascii_serializer against a digit-list model;
// instance 0 emits all digits, instance 1 suppresses leading zeros.
module tb_bcd_ascii_serializer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv[2], ir[2], ov[2], ordy[2], ol[2], oe[2];
  logic [15:0] bcd[2];
  logic [7:0]  oc[2], ec[2];
  int          nvec = 0, nerr = 0;
  int          err_model[2];

  always #5 clk = ~clk;

  bcd_ascii_serializer #(.DIGITS(4), .LZ_EN(1'b0), .ERR_CHAR(8'h3F)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_bcd(bcd[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_char(oc[0]), .out_last(ol[0]),
    .out_err(oe[0]), .err_cnt(ec[0]));

  bcd_ascii_serializer #(.DIGITS(4), .LZ_EN(1'b1), .ERR_CHAR(8'h3F)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_bcd(bcd[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_char(oc[1]), .out_last(ol[1]),
    .out_err(oe[1]), .err_cnt(ec[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: stall 3 cycles on the second char
  task automatic run_word(input int d, input logic [15:0] w, input int mode, output int cycles);
    int q_c[$], q_e[$], q_l[$];
    int top, ci, stall;
    logic rdy;
    top = 3;
    if (d == 1) begin
      top = 0;
      for (int i = 0; i < 4; i++) if (((int'(w) / (16 ** i)) % 16) != 0) top = i;
    end
    for (int i = top; i >= 0; i--) begin
      int dg;
      dg = (int'(w) / (16 ** i)) % 16;
      q_c.push_back(dg <= 9 ? 48 + dg : 63);
      q_e.push_back(dg > 9 ? 1 : 0);
      q_l.push_back(i == 0 ? 1 : 0);
    end
    @(negedge clk);
    chk("idle_ready", ir[d], 1);
    chk("idle_valid", ov[d], 0);
    iv[d] = 1'b1; bcd[d] = w;
    @(posedge clk); #1;
    iv[d] = 1'b0; bcd[d] = 16'($urandom);
    ci = 0; stall = 0; cycles = 0;
    while (ci < q_c.size() && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (mode == 0)      rdy = 1'b1;
      else if (mode == 1) rdy = 1'($urandom_range(0, 1));
      else                rdy = !(ci == 1 && stall < 3);
      if (!rdy && ci == 1) stall++;
      ordy[d] = rdy;
      chk("out_valid", ov[d], 1);
      chk("out_char", oc[d], q_c[ci]);
      chk("out_last", ol[d], q_l[ci]);
      chk("out_err", oe[d], q_e[ci]);
      chk("busy_ready", ir[d], 0);
      @(posedge clk);
      if (rdy) begin
        if (q_e[ci] == 1 && err_model[d] < 255) err_model[d]++;
        ci++;
      end
    end
    if (cycles >= 200) chk("timeout", 0, 1);
    @(negedge clk);
    ordy[d] = 1'b0;
    chk("end_valid", ov[d], 0);
    chk("end_ready", ir[d], 1);
    chk("err_cnt", ec[d], err_model[d]);
  endtask

  initial begin
    int cyc, d;
    logic [15:0] w;
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b0; bcd[i] = '0; err_model[i] = 0;
    end
    #2;
    chk("rst_ready", ir[0], 0);
    chk("rst_valid", ov[0], 0);
    chk("rst_char", oc[0], 0);
    chk("rst_errcnt", ec[0], 0);
    @(negedge clk); rst = 1'b0;

    run_word(0, 16'h0123, 0, cyc); chk("lat_0123", cyc, 4);
    run_word(1, 16'h0123, 0, cyc); chk("lat_lz_0123", cyc, 3);
    run_word(1, 16'h0000, 0, cyc); chk("lat_lz_0000", cyc, 1);
    run_word(1, 16'h0C00, 0, cyc); chk("lat_lz_0C00", cyc, 3);
    run_word(0, 16'hCAB3, 0, cyc); chk("errcnt_cab3", ec[0], 3);
    run_word(0, 16'hFFFF, 0, cyc); chk("errcnt_ffff", ec[0], 7);
    run_word(0, 16'h5555, 2, cyc); chk("stall_cycles", cyc, 7);

    // Reset in the middle of a word after two characters
    @(negedge clk);
    iv[0] = 1'b1; bcd[0] = 16'h1234;
    @(posedge clk); #1;
    iv[0] = 1'b0; ordy[0] = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", ov[0], 0);
    chk("mid_rst_char", oc[0], 0);
    chk("mid_rst_last", ol[0], 0);
    chk("mid_rst_errcnt", ec[0], 0);
    chk("mid_rst_ready", ir[0], 0);
    err_model[0] = 0; err_model[1] = 0;
    ordy[0] = 1'b0;
    @(negedge clk); rst = 1'b0;
    run_word(0, 16'h9876, 0, cyc); chk("lat_9876", cyc, 4);

    for (int n = 0; n < 40; n++) begin
      d = int'($urandom_range(0, 1));
      for (int k = 0; k < 4; k++)
        w[4*k +: 4] = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(0, 9)) : 4'($urandom);
      if ($urandom_range(0, 3) == 0) w[15:8] = 8'h00;
      run_word(d, w, 1, cyc);
    end

    // Drive the error counter into saturation
    for (int n = 0; n < 66; n++) run_word(0, 16'hFFFF, 0, cyc);
    chk("errcnt_sat", ec[0], 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
